// File: rtl/jt49_seq_if.sv
// rtl/jt49_seq_if.sv - command stream, PSG bus and read-back signals of jt49_seq
interface jt49_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [3:0]  psg_addr;
  logic        psg_cs_n;
  logic        psg_wr_n;
  logic [7:0]  psg_din;
  logic [7:0]  psg_dout;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;

  // command source and PSG model side
  modport master (
    output cmd_valid, cmd_op, cmd_arg, psg_dout,
    input  cmd_ready, psg_addr, psg_cs_n, psg_wr_n, psg_din, rd_data, rd_valid, busy
  );

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, psg_dout,
    output cmd_ready, psg_addr, psg_cs_n, psg_wr_n, psg_din, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/jt49_seq.sv
// rtl/jt49_seq.sv - queued PSG bus sequencer (write/read/wait); JT49_SEQ_READ_EN enables reads
module jt49_seq #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clk_en,
  jt49_seq_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
`ifdef JT49_SEQ_READ_EN
    S_RD,
    S_RDCAP,
`endif
    S_WAIT
  } state_t;

  // FIFO entries are {op, arg}
  logic [17:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                full, empty, push, pop;
  logic [1:0]          head_op;
  logic [15:0]         head_arg;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  din_q, din_d;

  // extra pointer bit separates full from empty when the index bits match
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign push     = bus.cmd_valid && !full;
  assign head_op  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]][17:16];
  assign head_arg = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]][15:0];

  // FIFO storage, written on every accepted command
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {bus.cmd_op, bus.cmd_arg};
  end

  // FIFO pointers; reset discards everything queued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

`ifdef JT49_SEQ_READ_EN
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
`endif

  // next state: pop in IDLE, one-cycle strobes, clk_en-paced wait countdown
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    pop        = 1'b0;
`ifdef JT49_SEQ_READ_EN
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          case (head_op)
            2'b00: begin
              state_d = S_WR;
              addr_d  = head_arg[11:8];
              din_d   = head_arg[7:0];
            end
`ifdef JT49_SEQ_READ_EN
            2'b01: begin
              state_d = S_RD;
              addr_d  = head_arg[11:8];
            end
`endif
            2'b10: begin
              if (head_arg != 16'd0) begin
                state_d = S_WAIT;
                cnt_d   = head_arg;
              end
            end
            default: ;
          endcase
        end
      end
      S_WR: state_d = S_IDLE;
`ifdef JT49_SEQ_READ_EN
      S_RD: state_d = S_RDCAP;
      S_RDCAP: begin
        rd_data_d  = bus.psg_dout;
        rd_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
`endif
      S_WAIT: begin
        if (clk_en) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sequencer registers; reset drops any in-flight command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      addr_q  <= 4'd0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

`ifdef JT49_SEQ_READ_EN
  // captured read value and its one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.psg_cs_n = !((state_q == S_WR) || (state_q == S_RD));
`else
  assign bus.rd_data  = 8'd0;
  assign bus.rd_valid = 1'b0;
  assign bus.psg_cs_n = !(state_q == S_WR);
`endif

  assign bus.psg_wr_n  = !(state_q == S_WR);
  assign bus.psg_addr  = addr_q;
  assign bus.psg_din   = din_q;
  assign bus.cmd_ready = !full;
  assign bus.busy      = !empty || (state_q != S_IDLE);

endmodule
